// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet-granular AXI4-Stream round-robin arbiter.
// Consumers: rr_pick and axis_rr_pkt_arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Sink capture FIFO depth; one grant never exceeds it.
  localparam int unsigned MAX_BEATS_DEFAULT = 1024;

  localparam int unsigned STAT_W = 16;

  // Bits needed to encode value-1; never less than one bit.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < value) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_rr_pick.sv
// Round-robin picker: rotate requests to start after ptr, take the lowest set
// bit, then rotate the winner back to an absolute index and one-hot vector.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IW = clogb2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  int unsigned          start;
  int unsigned          pos;
  logic                 hit;

  always_comb begin
    start = (32'(ptr) + 32'd1) % NUM_SRC;
    dbl   = {req, req};
    rot   = NUM_SRC'(dbl >> start);
    hit   = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rot[i] && !hit) begin
        hit = 1'b1;
        pos = i;
      end
    end
    idx    = IW'((pos + start) % NUM_SRC);
    onehot = hit ? (NUM_SRC'(1) << idx) : '0;
    found  = hit;
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink among NUM_SRC masters.
// Define AXIS_ARB_PKT_STATS_EN to add per-source PKT_CNT and TRUNC_CNT statistics outputs.
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC              = 4,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS            = MAX_BEATS_DEFAULT
) (
  input  logic                                    S_AXIS_ACLK,
  input  logic                                    S_AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                      S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]                      S_AXIS_TREADY,
  input  logic [NUM_SRC*C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                      S_AXIS_TLAST,
  output logic                                    M_AXIS_TVALID,
  input  logic                                    M_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
  output logic                                    M_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                      GRANT,
  output logic                                    BUSY
`ifdef AXIS_ARB_PKT_STATS_EN
  ,
  output logic [NUM_SRC*STAT_W-1:0]               PKT_CNT,
  output logic [STAT_W-1:0]                       TRUNC_CNT
`endif
);

  localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned IW = clogb2(NUM_SRC);
  localparam int unsigned CW = clogb2(MAX_BEATS + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_SRC-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [SW-1:0]      m_strb;
  logic               src_last;
  logic               at_limit;
  logic               beat;
  logic               eop;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req    (S_AXIS_TVALID),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // AND-OR mux keyed on the registered grant so idle ports never leak onto the sink.
  always_comb begin
    m_valid  = 1'b0;
    m_data   = '0;
    m_strb   = '0;
    src_last = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        m_valid  = m_valid | S_AXIS_TVALID[i];
        m_data   = m_data | S_AXIS_TDATA[i*DW +: DW];
        m_strb   = m_strb | S_AXIS_TSTRB[i*SW +: SW];
        src_last = src_last | S_AXIS_TLAST[i];
      end
    end
  end

  assign at_limit = (state_q == XFER) && (cnt_q == CW'(MAX_BEATS - 1));
  assign beat     = m_valid && M_AXIS_TREADY;
  assign eop      = beat && (src_last || at_limit);

  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = m_data;
  assign M_AXIS_TSTRB  = m_strb;
  assign M_AXIS_TLAST  = src_last || at_limit;
  assign S_AXIS_TREADY = grant_q & {NUM_SRC{M_AXIS_TREADY}};
  assign GRANT         = grant_q;
  assign BUSY          = (state_q == XFER);

  // Next-state: grant in IDLE, hold through XFER until the end-of-packet beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (eop) begin
          ptr_d   = idx_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef AXIS_ARB_PKT_STATS_EN
  logic [NUM_SRC-1:0][STAT_W-1:0] pkt_cnt_q;
  logic [STAT_W-1:0]              trunc_cnt_q;

  // Completed grants per source; truncations are limit hits without source TLAST.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else if (eop) begin
      pkt_cnt_q[idx_q] <= pkt_cnt_q[idx_q] + STAT_W'(1);
      if (at_limit && !src_last) begin
        trunc_cnt_q <= trunc_cnt_q + STAT_W'(1);
      end
    end
  end

  assign PKT_CNT   = pkt_cnt_q;
  assign TRUNC_CNT = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Self-checking bench for axis_rr_pkt_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin reference model.
module tb_axis_rr_pkt_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXB = 1024;
  localparam int QD   = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*SW-1:0] s_tstrb;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef AXIS_ARB_PKT_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic [15:0]     trunc_cnt;
`endif

  axis_rr_pkt_arbiter #(
    .NUM_SRC              (N),
    .C_S_AXIS_TDATA_WIDTH (DW),
    .MAX_BEATS            (MAXB)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rstn),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TREADY  (s_tready),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TSTRB   (s_tstrb),
    .S_AXIS_TLAST   (s_tlast),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TSTRB   (m_tstrb),
    .M_AXIS_TLAST   (m_tlast),
    .GRANT          (grant),
    .BUSY           (busy)
`ifdef AXIS_ARB_PKT_STATS_EN
    ,
    .PKT_CNT        (pkt_cnt),
    .TRUNC_CNT      (trunc_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-source beat queues (what each master will present, in order).
  logic [DW-1:0] q_data [N][QD];
  bit            q_last [N][QD];
  int            q_head [N];
  int            q_tail [N];
  bit            vld    [N];
  int            vpct = 100;
  int            rpct = 100;
  bit            rdy_pat[$];

  // Reference model state: current owner (-1 idle), pointer, beats in grant.
  int            m_owner = -1;
  int            m_ptr   = N - 1;
  int            m_cnt   = 0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  int            grant_log[$];
  logic [DW-1:0] sink_log[$];
  bit            sink_last[$];
  bit            grant_seen = 1'b0;
  int            bubbles = 0;

  function automatic logic [SW-1:0] strb_of(input logic [DW-1:0] d);
    return d[SW-1:0] ^ d[2*SW-1:SW];
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q_head[i] < q_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int s, input logic [DW-1:0] d, input bit last);
    if (q_tail[s] < QD) begin
      q_data[s][q_tail[s]] = d;
      q_last[s][q_tail[s]] = last;
      q_tail[s]++;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
      vld[i]    = 1'b0;
    end
    rdy_pat.delete();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    sink_log.delete();
    sink_last.delete();
    grant_seen = 1'b0;
    bubbles    = 0;
  endtask

  task automatic drive(input logic [N-1:0] pop);
    for (int i = 0; i < N; i++) begin
      if (pop[i]) begin
        q_head[i]++;
        vld[i] = 1'b0;
      end
      if (!vld[i] && q_head[i] < q_tail[i]) vld[i] = ($urandom_range(99) < vpct);
      s_tvalid[i] = vld[i];
      if (vld[i]) begin
        s_tdata[i*DW +: DW] = q_data[i][q_head[i]];
        s_tstrb[i*SW +: SW] = strb_of(q_data[i][q_head[i]]);
        s_tlast[i]          = q_last[i][q_head[i]];
      end else begin
        s_tdata[i*DW +: DW] = $urandom;
        s_tstrb[i*SW +: SW] = SW'($urandom);
        s_tlast[i]          = 1'($urandom);
      end
    end
    if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
    else m_tready = ($urandom_range(99) < rpct);
  endtask

  // Sampled at negedge: compare DUT against the model, then advance the model.
  task automatic monitor(output logic [N-1:0] pop);
    int            nxt;
    int            o;
    int            w;
    logic [N-1:0]  exp_gr;
    logic [DW-1:0] ed;
    bit            el;
    pop    = s_tvalid & s_tready;
    exp_gr = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("grant", grant, exp_gr);
    check("busy", busy, m_owner >= 0);
    check("s_tready", s_tready, exp_gr & {N{m_tready}});
    if (grant != 0) grant_seen = 1'b1;
    if (grant == 0 && grant_seen && !all_empty()) bubbles++;
    nxt = m_owner;
    if (m_owner < 0) begin
      check("m_tvalid_idle", m_tvalid, 0);
      check("m_tlast_idle", m_tlast, 0);
      if (rstn && s_tvalid != 0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && s_tvalid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        grant_log.push_back(w);
        nxt = w;
      end
    end else begin
      o = m_owner;
      check("m_tvalid", m_tvalid, s_tvalid[o]);
      if (hold_pend) check("hold_data", m_tdata, hold_data);
      hold_pend = 1'b0;
      if (s_tvalid[o]) begin
        ed = q_data[o][q_head[o]];
        el = q_last[o][q_head[o]] || (m_cnt == MAXB - 1);
        check("m_tdata", m_tdata, ed);
        check("m_tstrb", m_tstrb, strb_of(ed));
        check("m_tlast", m_tlast, el);
        if (m_tready) begin
          sink_log.push_back(m_tdata);
          sink_last.push_back(m_tlast);
          if (el) begin
            m_ptr = o;
            nxt   = -1;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end else begin
          hold_pend = 1'b1;
          hold_data = ed;
        end
      end
    end
    if (!rstn) begin
      nxt       = -1;
      m_ptr     = N - 1;
      m_cnt     = 0;
      hold_pend = 1'b0;
    end
    m_owner = nxt;
  endtask

  task automatic step();
    logic [N-1:0] pop;
    @(negedge clk);
    monitor(pop);
    @(posedge clk);
    #1;
    drive(pop);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(all_empty() && m_owner < 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
    step();
  endtask

  int total;
  int lasts;
  int n;

  initial begin
    rstn     = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    flush();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);

    // Single 3-beat packet from source 2.
    clear_logs();
    push(2, 32'hA, 1'b0);
    push(2, 32'hB, 1'b0);
    push(2, 32'hC, 1'b1);
    drive('0);
    step();
    check("t1_grant", grant, 4'b0100);
    run_done("t1", 50);
    check("t1_beats", sink_log.size(), 3);
    if (sink_log.size() == 3) begin
      check("t1_d0", sink_log[0], 32'hA);
      check("t1_d1", sink_log[1], 32'hB);
      check("t1_d2", sink_log[2], 32'hC);
      check("t1_last", {sink_last[0], sink_last[1], sink_last[2]}, 3'b001);
    end

    // Fairness: every source continuously valid with 2-beat packets.
    do_reset();
    flush();
    clear_logs();
    for (int s = 0; s < N; s++) begin
      for (int p = 0; p < 3; p++) begin
        push(s, 32'h2000_0000 + 32'(s * 16 + p * 2), 1'b0);
        push(s, 32'h2000_0001 + 32'(s * 16 + p * 2), 1'b1);
      end
    end
    drive('0);
    run_done("t2", 200);
    check("t2_grants", grant_log.size(), 12);
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("t2_order%0d", k), grant_log[k], k % N);
    end
    check("t2_bubbles", bubbles, 11);

    // Beat limit: source 1 sends 1030 beats with TLAST only on the last one.
    do_reset();
    flush();
    clear_logs();
    for (int k = 0; k < 1030; k++) push(1, 32'h1000_0000 + 32'(k), k == 1029);
    drive('0);
    repeat (5) step();
    for (int s = 0; s < N; s++) begin
      if (s != 1) begin
        push(s, 32'h3000_0000 + 32'(s * 2), 1'b0);
        push(s, 32'h3000_0001 + 32'(s * 2), 1'b1);
      end
    end
    drive('0);
    run_done("t3", 3000);
    check("t3_grants", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check("t3_g0", grant_log[0], 1);
      check("t3_g1", grant_log[1], 2);
      check("t3_g2", grant_log[2], 3);
      check("t3_g3", grant_log[3], 0);
      check("t3_g4", grant_log[4], 1);
    end
    check("t3_beats", sink_log.size(), 1036);
    if (sink_log.size() == 1036) begin
      check("t3_forced_last", sink_last[MAXB-1], 1);
      check("t3_forced_data", sink_log[MAXB-1], 32'h1000_0000 + 32'(MAXB - 1));
      check("t3_tail_last", sink_last[1035], 1);
      check("t3_tail_data", sink_log[1035], 32'h1000_0000 + 32'd1029);
    end
    lasts = 0;
    foreach (sink_last[k]) lasts += int'(sink_last[k]);
    check("t3_lasts", lasts, 5);
`ifdef AXIS_ARB_PKT_STATS_EN
    check("t3_pkt_cnt1", pkt_cnt[16 +: 16], 2);
    check("t3_pkt_cnt0", pkt_cnt[0 +: 16], 1);
    check("t3_trunc_cnt", trunc_cnt, 1);
`endif

    // Sink stalls mid-packet with ready pattern 1,0,0,1.
    do_reset();
    flush();
    clear_logs();
    for (int k = 0; k < 4; k++) push(0, 32'h4000_0000 + 32'(k), k == 3);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drive('0);
    run_done("t4", 50);
    check("t4_beats", sink_log.size(), 4);
    if (sink_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("t4_d%0d", k), sink_log[k], 32'h4000_0000 + 32'(k));
    end

    // Reset in the middle of a source-3 packet.
    do_reset();
    flush();
    clear_logs();
    for (int k = 0; k < 6; k++) push(3, 32'h5000_0000 + 32'(k), k == 5);
    drive('0);
    n = 0;
    while (sink_log.size() < 2 && n < 50) begin
      step();
      n++;
    end
    check("t5_mid_timeout", n < 50, 1);
    check("t5_busy_mid", busy, 1);
    do_reset();
    check("t5_rst_grant", grant, 0);
    check("t5_rst_tready", s_tready, 0);
    check("t5_rst_busy", busy, 0);
    flush();
    clear_logs();
    push(0, 32'h5100_0000, 1'b0);
    push(0, 32'h5100_0001, 1'b1);
    push(3, 32'h5300_0000, 1'b1);
    drive('0);
    run_done("t5", 100);
    check("t5_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check("t5_first", grant_log[0], 0);

    // Randomized traffic with valid gaps and sink backpressure.
    do_reset();
    flush();
    clear_logs();
    vpct  = 60;
    rpct  = 70;
    total = 0;
    for (int p = 0; p < 150; p++) begin
      int s;
      int len;
      s   = int'($urandom_range(N - 1));
      len = int'($urandom_range(6, 1));
      for (int k = 0; k < len; k++) push(s, $urandom, k == len - 1);
      total += len;
    end
    drive('0);
    run_done("t6", 20000);
    check("t6_beats", sink_log.size(), total);
    lasts = 0;
    foreach (sink_last[k]) lasts += int'(sink_last[k]);
    check("t6_lasts", lasts, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
